// File: rtl/write_back.sv
// rtl/write_back.sv - final pipeline stage: dual-slot register commit, write-through reads, forwarding record, retire count
// Slot L follows slot U in program order, so L wins when both target the same register.
module write_back (
  input  logic        clk,
  input  logic        rstn,
  input  logic        interlock,
  input  logic [31:0] pc,
  input  logic [63:0] inst,
  input  logic [4:0]  u_rt,
  input  logic        u_rt_flag,
  input  logic        u_hi_sel,
  input  logic [63:0] mem_doutb,
  input  logic [31:0] l_tdata,
  input  logic [4:0]  l_rt,
  input  logic        l_rt_flag,
  input  logic [4:0]  ra0,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  ra3,
  output logic [31:0] rd0,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] rd3,
  output logic [4:0]  fwd_u_rt,
  output logic        fwd_u_flag,
  output logic [31:0] fwd_u_data,
  output logic [4:0]  fwd_l_rt,
  output logic        fwd_l_flag,
  output logic [31:0] fwd_l_data,
  output logic [31:0] retired
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] retired_q, retired_d;
  logic [4:0]  fwd_u_rt_q, fwd_u_rt_d;
  logic        fwd_u_flag_q, fwd_u_flag_d;
  logic [31:0] fwd_u_data_q, fwd_u_data_d;
  logic [4:0]  fwd_l_rt_q, fwd_l_rt_d;
  logic        fwd_l_flag_q, fwd_l_flag_d;
  logic [31:0] fwd_l_data_q, fwd_l_data_d;

  logic [31:0] u_data;
  logic        u_commit;
  logic        l_commit;
  logic        u_write;
  logic [1:0]  slot_cnt;
  logic [4:0]  ra_arr [4];
  logic [31:0] rd_arr [4];
  logic        unused_dbg;

  // pc and the non-opcode instruction bits are carried for debug visibility only
  assign unused_dbg = ^{pc, inst[60:32], inst[28:0]};

  always_comb begin
    u_data   = u_hi_sel ? mem_doutb[63:32] : mem_doutb[31:0];
    u_commit = rstn && !interlock && u_rt_flag && (u_rt != 5'd0);
    l_commit = rstn && !interlock && l_rt_flag && (l_rt != 5'd0);
    u_write  = u_commit && !(l_commit && (l_rt == u_rt));
    slot_cnt = {1'b0, inst[63:61] != 3'b111} + {1'b0, inst[31:29] != 3'b111};
  end

  assign ra_arr[0] = ra0;
  assign ra_arr[1] = ra1;
  assign ra_arr[2] = ra2;
  assign ra_arr[3] = ra3;

  // Write-through: a commit in flight this cycle is visible to decode before the edge
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (ra_arr[k] == 5'd0) begin
        rd_arr[k] = '0;
      end else if (l_commit && (l_rt == ra_arr[k])) begin
        rd_arr[k] = l_tdata;
      end else if (u_commit && (u_rt == ra_arr[k])) begin
        rd_arr[k] = u_data;
      end else begin
        rd_arr[k] = regs_q[ra_arr[k]];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    retired_d    = retired_q;
    fwd_u_rt_d   = fwd_u_rt_q;
    fwd_u_flag_d = fwd_u_flag_q;
    fwd_u_data_d = fwd_u_data_q;
    fwd_l_rt_d   = fwd_l_rt_q;
    fwd_l_flag_d = fwd_l_flag_q;
    fwd_l_data_d = fwd_l_data_q;

    if (!interlock) begin
      retired_d    = retired_q + {30'd0, slot_cnt};
      fwd_u_rt_d   = u_rt;
      fwd_u_flag_d = u_commit;
      fwd_u_data_d = u_data;
      fwd_l_rt_d   = l_rt;
      fwd_l_flag_d = l_commit;
      fwd_l_data_d = l_tdata;
    end else begin
      fwd_u_flag_d = 1'b0;
      fwd_l_flag_d = 1'b0;
    end

    if (u_write) begin
      regs_d[u_rt] = u_data;
    end
    if (l_commit) begin
      regs_d[l_rt] = l_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      retired_q    <= '0;
      fwd_u_rt_q   <= '0;
      fwd_u_flag_q <= 1'b0;
      fwd_u_data_q <= '0;
      fwd_l_rt_q   <= '0;
      fwd_l_flag_q <= 1'b0;
      fwd_l_data_q <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      retired_q    <= retired_d;
      fwd_u_rt_q   <= fwd_u_rt_d;
      fwd_u_flag_q <= fwd_u_flag_d;
      fwd_u_data_q <= fwd_u_data_d;
      fwd_l_rt_q   <= fwd_l_rt_d;
      fwd_l_flag_q <= fwd_l_flag_d;
      fwd_l_data_q <= fwd_l_data_d;
    end
  end

  assign rd0        = rd_arr[0];
  assign rd1        = rd_arr[1];
  assign rd2        = rd_arr[2];
  assign rd3        = rd_arr[3];
  assign fwd_u_rt   = fwd_u_rt_q;
  assign fwd_u_flag = fwd_u_flag_q;
  assign fwd_u_data = fwd_u_data_q;
  assign fwd_l_rt   = fwd_l_rt_q;
  assign fwd_l_flag = fwd_l_flag_q;
  assign fwd_l_data = fwd_l_data_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_write_back.sv
// tb/tb_write_back.sv - directed scoreboard bench for write_back
module tb_write_back;

  localparam logic [63:0] NOPS = 64'hE000_0000_E000_0000;
  localparam logic [63:0] TWO  = 64'h0000_0001_0000_0002;
  localparam logic [63:0] UNOP = 64'hE000_0000_0000_0002;
  localparam logic [63:0] LNOP = 64'h0000_0001_E000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        interlock;
  logic [31:0] pc;
  logic [63:0] inst;
  logic [4:0]  u_rt;
  logic        u_rt_flag;
  logic        u_hi_sel;
  logic [63:0] mem_doutb;
  logic [31:0] l_tdata;
  logic [4:0]  l_rt;
  logic        l_rt_flag;
  logic [4:0]  ra0, ra1, ra2, ra3;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic [4:0]  fwd_u_rt, fwd_l_rt;
  logic        fwd_u_flag, fwd_l_flag;
  logic [31:0] fwd_u_data, fwd_l_data;
  logic [31:0] retired;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_ret = 32'd0;

  write_back dut (
    .clk(clk), .rstn(rstn), .interlock(interlock), .pc(pc), .inst(inst),
    .u_rt(u_rt), .u_rt_flag(u_rt_flag), .u_hi_sel(u_hi_sel), .mem_doutb(mem_doutb),
    .l_tdata(l_tdata), .l_rt(l_rt), .l_rt_flag(l_rt_flag),
    .ra0(ra0), .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd0(rd0), .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .fwd_u_rt(fwd_u_rt), .fwd_u_flag(fwd_u_flag), .fwd_u_data(fwd_u_data),
    .fwd_l_rt(fwd_l_rt), .fwd_l_flag(fwd_l_flag), .fwd_l_data(fwd_l_data),
    .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty obs=%h exp=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive(input logic [63:0] i, input logic [4:0] urt, input logic uf,
                       input logic hs, input logic [63:0] mem, input logic [4:0] lrt,
                       input logic lf, input logic [31:0] ld);
    inst      = i;
    u_rt      = urt;
    u_rt_flag = uf;
    u_hi_sel  = hs;
    mem_doutb = mem;
    l_rt      = lrt;
    l_rt_flag = lf;
    l_tdata   = ld;
  endtask

  task automatic idle();
    drive(NOPS, 5'd0, 1'b0, 1'b0, 64'd0, 5'd0, 1'b0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    interlock = 1'b0;
    pc = 32'h0000_1000;
    ra0 = 5'd0; ra1 = 5'd0; ra2 = 5'd0; ra3 = 5'd0;
    idle();
    tick();
    tick();
    rstn = 1'b1;

    // reset state
    push("rst_retired", 32'd0);
    push("rst_fwd_u_flag", 32'd0);
    push("rst_fwd_l_flag", 32'd0);
    push("rst_fwd_u_rt", 32'd0);
    push("rst_fwd_l_data", 32'd0);
    settle();
    pop_chk(retired);
    pop_chk({31'd0, fwd_u_flag});
    pop_chk({31'd0, fwd_l_flag});
    pop_chk({27'd0, fwd_u_rt});
    pop_chk(fwd_l_data);

    // preload r1..r4
    drive(TWO, 5'd1, 1'b1, 1'b0, 64'h0BAD_0BAD_1111_1111, 5'd2, 1'b1, 32'h2222_2222);
    tick();
    drive(TWO, 5'd3, 1'b1, 1'b1, 64'h3333_3333_0BAD_0BAD, 5'd4, 1'b1, 32'h4444_4444);
    tick();
    exp_ret = exp_ret + 32'd4;
    idle();
    ra0 = 5'd1; ra1 = 5'd2; ra2 = 5'd3; ra3 = 5'd4;
    push("pre_r1", 32'h1111_1111);
    push("pre_r2", 32'h2222_2222);
    push("pre_r3", 32'h3333_3333);
    push("pre_r4", 32'h4444_4444);
    push("pre_retired", exp_ret);
    settle();
    pop_chk(rd0); pop_chk(rd1); pop_chk(rd2); pop_chk(rd3); pop_chk(retired);

    // reset with a commit presented: commit dropped, everything cleared
    drive(TWO, 5'd6, 1'b1, 1'b0, 64'h0000_0000_6666_6666, 5'd5, 1'b1, 32'h5555_5555);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    idle();
    exp_ret = 32'd0;
    push("rst_r1", 32'd0);
    push("rst_r2", 32'd0);
    push("rst_r3", 32'd0);
    push("rst_r4", 32'd0);
    push("rst2_retired", 32'd0);
    push("rst2_fwd_l_flag", 32'd0);
    settle();
    pop_chk(rd0); pop_chk(rd1); pop_chk(rd2); pop_chk(rd3); pop_chk(retired);
    pop_chk({31'd0, fwd_l_flag});
    ra0 = 5'd5; ra1 = 5'd6;
    push("rst_r5", 32'd0);
    push("rst_r6", 32'd0);
    settle();
    pop_chk(rd0); pop_chk(rd1);

    // dual commit
    drive(TWO, 5'd3, 1'b1, 1'b1, 64'hAAAA_0000_5555_FFFF, 5'd4, 1'b1, 32'h1234_5678);
    push("dual_fwd_u_data", 32'hAAAA_0000);
    push("dual_fwd_u_flag", 32'd1);
    push("dual_fwd_u_rt", 32'd3);
    push("dual_fwd_l_data", 32'h1234_5678);
    push("dual_fwd_l_flag", 32'd1);
    tick();
    exp_ret = exp_ret + 32'd2;
    pop_chk(fwd_u_data); pop_chk({31'd0, fwd_u_flag}); pop_chk({27'd0, fwd_u_rt});
    pop_chk(fwd_l_data); pop_chk({31'd0, fwd_l_flag});
    idle();
    ra0 = 5'd3; ra1 = 5'd4;
    push("dual_r3", 32'hAAAA_0000);
    push("dual_r4", 32'h1234_5678);
    settle();
    pop_chk(rd0); pop_chk(rd1);
    push("fwd_one_cycle_u", 32'd0);
    push("fwd_one_cycle_l", 32'd0);
    push("dual_retired", exp_ret);
    tick();
    pop_chk({31'd0, fwd_u_flag}); pop_chk({31'd0, fwd_l_flag}); pop_chk(retired);

    // U low half selection, L slot nop
    drive(LNOP, 5'd6, 1'b1, 1'b0, 64'hAAAA_0000_5555_FFFF, 5'd0, 1'b0, 32'd0);
    tick();
    exp_ret = exp_ret + 32'd1;
    idle();
    ra1 = 5'd6;
    push("lo_r6", 32'h5555_FFFF);
    push("lo_retired", exp_ret);
    settle();
    pop_chk(rd1); pop_chk(retired);

    // same-target conflict: L wins
    drive(TWO, 5'd7, 1'b1, 1'b0, 64'h0000_0000_0000_0011, 5'd7, 1'b1, 32'h0000_0022);
    ra0 = 5'd7;
    push("conf_wt_r7", 32'h0000_0022);
    settle();
    pop_chk(rd0);
    tick();
    exp_ret = exp_ret + 32'd2;
    idle();
    push("conf_r7", 32'h0000_0022);
    settle();
    pop_chk(rd0);

    // write-through and r0
    drive(UNOP, 5'd0, 1'b0, 1'b0, 64'd0, 5'd5, 1'b1, 32'hDEAD_BEEF);
    ra2 = 5'd5;
    push("wt_r5", 32'hDEAD_BEEF);
    settle();
    pop_chk(rd2);
    tick();
    exp_ret = exp_ret + 32'd1;
    drive(UNOP, 5'd0, 1'b0, 1'b0, 64'd0, 5'd0, 1'b1, 32'h0000_00FF);
    ra3 = 5'd0;
    push("r0_wt", 32'd0);
    settle();
    pop_chk(rd3);
    push("r0_fwd_l_flag", 32'd0);
    push("r0_fwd_l_data", 32'h0000_00FF);
    push("r5_kept", 32'hDEAD_BEEF);
    tick();
    exp_ret = exp_ret + 32'd1;
    pop_chk({31'd0, fwd_l_flag}); pop_chk(fwd_l_data); pop_chk(rd2);

    // interlock blocks commit, holds retired, clears fwd flags, holds fwd data
    drive(TWO, 5'd0, 1'b0, 1'b0, 64'd0, 5'd9, 1'b1, 32'h0000_0099);
    interlock = 1'b1;
    ra0 = 5'd9;
    push("il_wt_r9", 32'd0);
    settle();
    pop_chk(rd0);
    push("il_r9", 32'd0);
    push("il_retired", exp_ret);
    push("il_fwd_l_flag", 32'd0);
    push("il_fwd_u_flag", 32'd0);
    push("il_fwd_l_data", 32'h0000_00FF);
    tick();
    pop_chk(rd0); pop_chk(retired); pop_chk({31'd0, fwd_l_flag});
    pop_chk({31'd0, fwd_u_flag}); pop_chk(fwd_l_data);
    interlock = 1'b0;
    push("ilx_wt_r9", 32'h0000_0099);
    settle();
    pop_chk(rd0);
    push("ilx_fwd_l_flag", 32'd1);
    tick();
    exp_ret = exp_ret + 32'd2;
    pop_chk({31'd0, fwd_l_flag});
    idle();
    push("ilx_r9", 32'h0000_0099);
    push("ilx_retired", exp_ret);
    settle();
    pop_chk(rd0); pop_chk(retired);

    // counter from reset: 2 + 1 + 0 = 3, flags ignored
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    drive(TWO, 5'd0, 1'b0, 1'b0, 64'd0, 5'd0, 1'b0, 32'd0);
    tick();
    drive(UNOP, 5'd0, 1'b0, 1'b0, 64'd0, 5'd0, 1'b0, 32'd0);
    tick();
    drive(NOPS, 5'd0, 1'b0, 1'b0, 64'd0, 5'd0, 1'b0, 32'd0);
    push("cnt_retired", 32'd3);
    tick();
    pop_chk(retired);

    // wrap from all-ones with two slots
    dut.retired_q = 32'hFFFF_FFFF;
    drive(TWO, 5'd0, 1'b0, 1'b0, 64'd0, 5'd0, 1'b0, 32'd0);
    push("wrap_retired", 32'd1);
    tick();
    pop_chk(retired);
    idle();

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover obs=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/write_back.md
# write_back

Final pipeline stage: consumes the memory stage's outputs and commits up to two results per cycle into a 32×32 general register file. Slot U (upper half of the 64-bit bundle) carries load data taken from the 64-bit memory word; slot L (lower half) carries ALU data. The block also exposes four write-through read ports to decode, a one-cycle forwarding record, and a retired-slot counter.

## Interface
- No parameters; register count is fixed at 32 and data width at 32.
- clk  in  1  clock; all state updates on posedge
- rstn  in  1  synchronous reset, active-low
- interlock  in  1  pipeline stall; no commit while high
- pc  in  32  pc of the bundle in this stage (debug only)
- inst  in  64  bundle; slot U is [63:32], slot L is [31:0]; a slot whose top bits [31:29] are 3'b111 is a nop
- u_rt, u_rt_flag  in  5, 1  slot U destination and write enable
- u_hi_sel  in  1  1: U data = mem_doutb[63:32]; 0: U data = mem_doutb[31:0]
- mem_doutb  in  64  memory word for slot U
- l_tdata, l_rt, l_rt_flag  in  32, 5, 1  slot L data, destination, write enable
- ra0..ra3  in  5 each  read addresses from decode
- rd0..rd3  out  32 each  read data, combinational
- fwd_u_rt, fwd_u_flag, fwd_u_data  out  5, 1, 32  registered copy of last committed U write
- fwd_l_rt, fwd_l_flag, fwd_l_data  out  5, 1, 32  registered copy of last committed L write
- retired  out  32  count of committed non-nop slots

## Operation
- Commit condition per slot: rstn=1, interlock=0, slot flag=1, destination≠0.
- At posedge with commit: regs[u_rt] ← U data; regs[l_rt] ← l_tdata.
- Both slots targeting the same register in one cycle: L wins (L follows U in program order). U is not written in that cycle.
- Register 0: reads always 0; writes are discarded; flag is still forwarded with fwd_*_flag=0.
- Read port k: if ra_k=0 → 0; else if an L commit this cycle targets ra_k → l_tdata; else if a U commit this cycle targets ra_k → U data; else regs[ra_k]. The ports are pure combinational over current inputs and state.
- Forwarding record: on each non-interlocked posedge, fwd_x_rt/data ← the slot's rt/data and fwd_x_flag ← commit condition of that slot. With interlock=1, both fwd flags are cleared and rt/data hold their values.
- retired: on each non-interlocked posedge, increments by the number of non-nop slots in inst (0, 1 or 2), independent of the flags. Wraps modulo 2^32 without saturating.
- interlock=1: no regfile write, retired holds, fwd flags are cleared.

## Timing
- Reset (rstn=0 at posedge): all 32 registers are set to 0, retired=0, fwd_*_flag=0, fwd_*_rt=0, fwd_*_data=0. Reset takes priority over interlock and all commits.
- Write latency: data presented in cycle n is visible in regs after posedge n. Through the read ports it is visible already in cycle n via write-through.
- fwd_* outputs are valid for exactly one cycle after the commit edge.
- Reset asserted while a commit is presented: the commit is dropped and the register stays 0.
- retired transition from 0xFFFFFFFF with two retiring slots gives 0x00000001.

## Test plan
- Reset: preload regs with nonzero values, pulse rstn=0 for one cycle → every rdk reads 0, retired=0, fwd flags=0.
- Dual commit: u_rt=3, u_flag=1, u_hi_sel=1, mem_doutb=0xAAAA0000_5555FFFF; l_rt=4, l_flag=1, l_tdata=0x12345678 → after the edge, ra0=3 gives 0xAAAA0000 and ra1=4 gives 0x12345678; fwd_u_data=0xAAAA0000.
- Same-target conflict: u_rt=l_rt=7, U data=0x11, l_tdata=0x22 → rd(7)=0x22 both in the same cycle and after the edge.
- Write-through and r0: l_rt=5, l_tdata=0xDEADBEEF with ra2=5 → rd2=0xDEADBEEF before the edge. l_rt=0, l_tdata=0xFF → rd(0)=0 and fwd_l_flag=0.
- Interlock: commit to r9=0x99 while interlock=1 → r9 is unchanged, retired is unchanged, fwd flags=0. Deasserting interlock with the same inputs commits them.
- Counter: 3 bundles (two real slots, one nop slot + one real slot, two nop slots) → retired=3. Force retired=0xFFFFFFFF, then apply a two-slot bundle → retired=1.
